ahb_write_fifo: RTL and testbench
=================================

# ahb_write_fifo

Parametrised AHB-Lite write buffer: accepts AHB write transfers, queues data with per-entry parity in a DEPTH-entry FIFO, and drains entries to a downstream consumer over a four-phase YREQ/YACK handshake. Successor to the single-register write buffer, adding configurable width and depth, back-pressure via HREADYOUT, selectable even/odd parity per entry, and a readable status word. Sits between the AHB-Lite interconnect and a slow peripheral (display/serial sink).

## Interface
Parameters:
- DATA_W, 32, width of stored/forwarded data (8, 16 or 32); stored from HWDATA[DATA_W-1:0]
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HWRITE  in  1  1 = write transfer
- HTRANS  in  2  AHB transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are transfers
- HSIZE  in  3  transfer size; ignored, full DATA_W lane stored
- HADDR  in  32  address; ignored (single-location slave)
- HWDATA  in  32  write data, valid in data phase
- HREADY  in  1  bus ready; address phase accepted only when high
- HREADYOUT  out  1  slave ready; low inserts wait states
- HRDATA  out  32  status word on reads
- PARTYSEL  in  1  parity mode sampled at push: 0 even, 1 odd
- YDATA  out  DATA_W  head entry data to consumer
- YPARITY  out  1  parity bit stored with head entry
- YREQ  out  1  request, data valid
- YACK  in  1  consumer acknowledge

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]; registers wr_pend = HWRITE, rd_pend = !HWRITE.
- Write data phase: if FIFO not full, push {HWDATA[DATA_W-1:0], par} where par = ^data when PARTYSEL=0, ~^data when PARTYSEL=1 (data+parity has even/odd ones). If full, HREADYOUT=0 and the push retries every cycle until a slot frees; PARTYSEL and HWDATA are sampled in the cycle the push occurs.
- HREADYOUT = !(wr_pend & full); depends only on registered state (no YACK→HREADYOUT path).
- Read data phase: zero-wait; HRDATA = {14'b0, empty, full, count zero-extended to 16}; HRDATA = 0 when not in a read data phase.
- Drain FSM states: IDLE → REQ when FIFO non-empty (YDATA/YPARITY loaded from head, YREQ=1); REQ → ACKWAIT when YACK=1 (pop head, YREQ=0); ACKWAIT → IDLE when YACK=0. YACK high in IDLE is ignored.
- Simultaneous push and pop: both occur, count unchanged; pop at full does not unblock a push in the same cycle (push completes next cycle).
- Pointers wrap modulo DEPTH; count 0..DEPTH; empty = count==0, full = count==DEPTH.
- Reset (any time, including mid-handshake or wait state): FIFO emptied, FSM to IDLE, pending phases cleared; in-flight entries discarded.

## Timing
- Reset values: HREADYOUT=1, HRDATA=0, YREQ=0, YDATA=0, YPARITY=0, count=0.
- Write address phase in cycle N, FIFO empty and idle → pushed at edge ending N+1 → YREQ=1 from N+2 (2-cycle latency).
- YACK sampled high at edge E → YREQ=0 after E; next YREQ earliest one cycle after YACK is seen low.
- YDATA/YPARITY stable whenever YREQ=1.
- Back-to-back writes sustain one per cycle while not full.

## Structure
- Package ahb_write_fifo_pkg: HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), drain FSM state enum, parity function par(data, odd).
- Sub-module sync_fifo (parameters WIDTH=DATA_W+1, DEPTH): push/pop/full/empty/count, registered storage, synchronous active-high reset.

## Test plan
- Reset mid-handshake: 3 entries queued, YREQ=1, assert HRESET one cycle → YREQ=0, HRDATA read gives 0x0002_0000 (empty), HREADYOUT=1.
- Single write 0xA5 (DATA_W=8), PARTYSEL=0 → YREQ at N+2, YDATA=0xA5, YPARITY=0; with PARTYSEL=1 → YPARITY=1.
- DEPTH=4, YACK held low, 5 back-to-back writes 1..5 → 5th data phase holds HREADYOUT=0; status read blocked until one YACK cycle, then 5 pushed; drained order 1,2,3,4,5.
- Full-cycle handshake: YACK asserted 3 cycles then dropped → exactly one pop, next YREQ not before YACK low.
- Interleaved write/drain at steady state (push and pop same cycle) → count stays constant, no data loss over 64 random words, parity correct on each.
- Read status with 2 entries → HRDATA=0x0000_0002 zero-wait; HTRANS=BUSY or HSEL=0 writes → no push.

Source files
------------

// File: rtl/ahb_write_fifo_pkg.sv
// Shared types for the AHB-Lite write FIFO: bus transfer encodings, drain FSM states
// and the per-entry parity helper.
package ahb_write_fifo_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAckWait
  } drain_state_e;

  localparam int unsigned StatusCntW = 16;

  // Parity bit that makes data+parity carry an even (odd=0) or odd (odd=1) number of ones.
  function automatic logic par(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/ahb_write_fifo_sync_fifo.sv
// Single-clock FIFO with registered storage, occupancy count and synchronous reset.
// Pushes when full and pops when empty are ignored.
module sync_fifo
  import ahb_write_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ahb_write_fifo.sv
// AHB-Lite write buffer: queues write data with parity and drains it to a slow consumer
// over a four-phase YREQ/YACK handshake; reads return a FIFO status word.
module ahb_write_fifo
  import ahb_write_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HADDR,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  input  logic              PARTYSEL,
  output logic [DATA_W-1:0] YDATA,
  output logic              YPARITY,
  output logic              YREQ,
  input  logic              YACK
);

  localparam int unsigned EntryW = DATA_W + 1;

  drain_state_e      state_q;
  logic              wr_pend_q, rd_pend_q;
  logic              accept, push, pop, full, empty;
  logic [CNT_W-1:0]  count;
  logic [EntryW-1:0] push_word, head_word;
  logic              unused_ok;

  assign unused_ok = ^{HSIZE, HADDR, HWDATA};

  assign accept = HSEL & HREADY &
                  ((HTRANS == HtransNonseq) || (HTRANS == HtransSeq));

  // Push decision uses registered full, so a same-cycle pop never unblocks a push.
  assign push      = wr_pend_q & ~full;
  assign push_word = {HWDATA[DATA_W-1:0], par(32'(HWDATA[DATA_W-1:0]), PARTYSEL)};
  assign pop       = (state_q == StReq) & YACK;

  assign HREADYOUT = ~(wr_pend_q & full);
  assign HRDATA    = rd_pend_q ? {14'b0, empty, full, StatusCntW'(count)} : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else if (HREADY) begin
      wr_pend_q <= accept & HWRITE;
      rd_pend_q <= accept & ~HWRITE;
    end else if (push) begin
      wr_pend_q <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // An empty FIFO forwards the word being pushed so YREQ rises with the push itself.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      YREQ    <= 1'b0;
      YDATA   <= '0;
      YPARITY <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty || push) begin
            state_q          <= StReq;
            YREQ             <= 1'b1;
            {YDATA, YPARITY} <= empty ? push_word : head_word;
          end
        end
        StReq: begin
          if (YACK) begin
            state_q <= StAckWait;
            YREQ    <= 1'b0;
          end
        end
        StAckWait: begin
          if (!YACK) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_write_fifo.sv
// Randomised self-checking bench for ahb_write_fifo: a queue scoreboard checks drained
// data/parity order, directed sequences check latency, back-pressure and status words.
module tb_ahb_write_fifo;

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, PARTYSEL, YPARITY, YREQ, YACK;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR, HWDATA, HRDATA, YDATA;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_write_fifo #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .PARTYSEL  (PARTYSEL),
    .YDATA     (YDATA),
    .YPARITY   (YPARITY),
    .YREQ      (YREQ),
    .YACK      (YACK)
  );

  typedef struct packed {
    logic        wr;
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] data;
    logic        psel;
  } op_t;

  op_t         op_q[$];
  logic [32:0] exp_q[$];  // {parity, data} in the order the bus delivered them
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops = 0;
  int          cons_mode = 0;  // 0: YACK low, 1: random handshake, 2: YACK high

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [31:0] d, input logic odd);
    return (($countones(d) % 2) != 0) ^ odd;
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic add_op(input logic wr, input logic sel, input logic [1:0] trans,
                        input logic [31:0] data, input logic psel);
    op_t o;
    o.wr = wr; o.sel = sel; o.trans = trans; o.data = data; o.psel = psel;
    op_q.push_back(o);
  endtask

  // Pipelined AHB master: address phase of op i overlaps the data phase of op i-1.
  task automatic bus_run(output int stalls);
    int  n;
    int  guard;
    op_t p;
    n = op_q.size();
    stalls = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = op_q[i].sel; HWRITE = op_q[i].wr; HTRANS = op_q[i].trans;
      end else begin
        HSEL = 1'b0; HWRITE = 1'b0; HTRANS = TrIdle;
      end
      if (i > 0) begin
        p = op_q[i-1];
        HWDATA = p.data; PARTYSEL = p.psel;
      end
      guard = 0;
      while (!HREADYOUT && guard < 200) begin
        step();
        guard++;
        stalls++;
      end
      if (guard >= 200) check_eq("bus_timeout", {31'b0, HREADYOUT}, 32'd1);
      if (i > 0 && p.sel && p.trans[1]) begin
        if (p.wr) exp_q.push_back({exp_par(p.data, p.psel), p.data});
        else      rd_q.push_back(HRDATA);
      end
      step();
    end
    op_q.delete();
  endtask

  task automatic drain();
    int guard = 0;
    cons_mode = 1;
    while (exp_q.size() != 0 && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) check_eq("drain_timeout", exp_q.size(), 0);
    cons_mode = 0;
    repeat (3) step();
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    int st;
    rd_q.delete();
    add_op(1'b0, 1'b1, TrNonseq, 32'h0, 1'b0);
    bus_run(st);
    check_eq(tag, (rd_q.size() == 1) ? rd_q[0] : 32'hxxxx_xxxx, exp);
  endtask

  // Consumer: drives YACK half a step after the main thread and scores every pop.
  initial begin
    logic [32:0] e;
    YACK = 1'b0;
    forever begin
      @(posedge HCLK);
      #2;
      case (cons_mode)
        0: YACK = 1'b0;
        2: YACK = 1'b1;
        default: begin
          if (YREQ && !YACK)      YACK = ($urandom_range(0, 2) != 0);
          else if (!YREQ && YACK) YACK = ($urandom_range(0, 1) != 0);
        end
      endcase
      if (YREQ && YACK && !HRESET) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check_eq("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("ydata", YDATA, e[31:0]);
          check_eq("yparity", {31'b0, YPARITY}, {31'b0, e[32]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int st;
    int pops0;
    HSEL = 0; HWRITE = 0; HTRANS = TrIdle; HSIZE = 3'b010; HADDR = 32'h0;
    HWDATA = 32'h0; PARTYSEL = 0; HRESET = 1;
    repeat (2) step();
    HRESET = 0;

    // Reset values
    check_eq("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check_eq("rst_hrdata", HRDATA, 32'h0);
    check_eq("rst_yreq", {31'b0, YREQ}, 32'd0);
    check_eq("rst_ydata", YDATA, 32'h0);
    check_eq("rst_yparity", {31'b0, YPARITY}, 32'd0);
    read_status("rst_status", 32'h0002_0000);

    // Single write, even then odd parity; YREQ must be up right after the data phase
    add_op(1'b1, 1'b1, TrNonseq, 32'h0000_00A5, 1'b0);
    bus_run(st);
    check_eq("single_yreq", {31'b0, YREQ}, 32'd1);
    check_eq("single_ydata", YDATA, 32'h0000_00A5);
    check_eq("single_par_even", {31'b0, YPARITY}, 32'd0);
    drain();
    add_op(1'b1, 1'b1, TrNonseq, 32'h0000_00A5, 1'b1);
    bus_run(st);
    check_eq("single_yreq_odd", {31'b0, YREQ}, 32'd1);
    check_eq("single_par_odd", {31'b0, YPARITY}, 32'd1);
    drain();

    // Status with two entries; BUSY and unselected writes must not push
    add_op(1'b1, 1'b1, TrNonseq, 32'h1111_0001, 1'b0);
    add_op(1'b1, 1'b1, TrSeq,    32'h2222_0002, 1'b1);
    add_op(1'b0, 1'b1, TrNonseq, 32'h0, 1'b0);
    add_op(1'b1, 1'b1, TrBusy,   32'hDEAD_0000, 1'b0);
    add_op(1'b1, 1'b0, TrNonseq, 32'hBEEF_0000, 1'b0);
    rd_q.delete();
    bus_run(st);
    check_eq("status_two", (rd_q.size() == 1) ? rd_q[0] : 32'hxxxx_xxxx, 32'h0000_0002);
    check_eq("status_zero_wait", st, 0);
    read_status("status_no_push", 32'h0000_0002);

    // Full handshake: YACK high for three cycles pops once; next YREQ waits for YACK low
    check_eq("hs_req_before", {31'b0, YREQ}, 32'd1);
    cons_mode = 2;
    step();
    check_eq("hs_req_drop", {31'b0, YREQ}, 32'd0);
    step();
    check_eq("hs_req_held_low1", {31'b0, YREQ}, 32'd0);
    step();
    cons_mode = 0;
    check_eq("hs_req_held_low2", {31'b0, YREQ}, 32'd0);
    step();
    check_eq("hs_req_after_low", {31'b0, YREQ}, 32'd0);
    step();
    check_eq("hs_req_again", {31'b0, YREQ}, 32'd1);
    check_eq("hs_second_data", YDATA, 32'h2222_0002);
    check_eq("hs_one_pop", exp_q.size(), 1);
    drain();

    // Back-pressure: five writes into four slots, status read queued behind them
    pops0 = n_pops;
    for (int k = 1; k <= 5; k++) add_op(1'b1, 1'b1, TrNonseq, 32'(k), 1'(k % 2));
    add_op(1'b0, 1'b1, TrNonseq, 32'h0, 1'b0);
    rd_q.delete();
    fork
      bus_run(st);
      begin
        repeat (5) step();
        check_eq("bp_stall_c5", {31'b0, HREADYOUT}, 32'd0);
        step();
        check_eq("bp_stall_c6", {31'b0, HREADYOUT}, 32'd0);
        cons_mode = 2;
        step();
        cons_mode = 0;
        check_eq("bp_release", {31'b0, HREADYOUT}, 32'd1);
      end
    join
    check_eq("bp_stalls", st, 2);
    check_eq("bp_status", (rd_q.size() == 1) ? rd_q[0] : 32'hxxxx_xxxx, 32'h0001_0004);
    drain();
    check_eq("bp_pops", n_pops - pops0, 5);

    // Random traffic against a randomly acknowledging consumer
    pops0 = n_pops;
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(0, 3) == 0) add_op(1'b1, 1'b0, TrNonseq, $urandom, 1'b0);
      add_op(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? TrSeq : TrNonseq, $urandom,
             1'($urandom_range(0, 1)));
    end
    cons_mode = 1;
    bus_run(st);
    drain();
    check_eq("rand_pops", n_pops - pops0, 64);
    read_status("rand_empty", 32'h0002_0000);

    // Reset mid-handshake discards queued entries
    for (int k = 0; k < 3; k++) add_op(1'b1, 1'b1, TrNonseq, 32'hC0DE_0000 + 32'(k), 1'b0);
    bus_run(st);
    check_eq("mid_yreq", {31'b0, YREQ}, 32'd1);
    HRESET = 1;
    step();
    HRESET = 0;
    exp_q.delete();
    check_eq("mid_rst_yreq", {31'b0, YREQ}, 32'd0);
    check_eq("mid_rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    repeat (3) step();
    check_eq("mid_rst_stays_idle", {31'b0, YREQ}, 32'd0);
    read_status("mid_rst_status", 32'h0002_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
